csi_tx_lane_ctrl: RTL and testbench
===================================

// Module: csi_tx_lane_ctrl
// PURPOSE
//  Single-lane MIPI CSI-2 D-PHY transmit sequencer, byte-clock domain. Accepts payload bytes
//  via valid/ready and emits the per-lane LP/HS sequence: LP-11, LP-01, LP-00, HS-zero,
//  sync 0xB8, payload, HS-trail, LP-11. Drives an 8:1 OSERDES (HS path) and LP drivers;
//  the transmit counterpart of the lane receive PHY.
// PARAMETERS
//  T_LPX        4   LP-01 duration, byte clocks (1..255; 0 treated as 1)
//  T_HS_PREPARE 3   LP-00 duration, byte clocks (1..255; 0 treated as 1)
//  T_HS_ZERO    10  HS 0x00 bytes before sync (1..255; 0 treated as 1)
//  T_HS_TRAIL   5   trail bytes after last payload byte (1..255; 0 treated as 1)
//  T_HS_EXIT    6   forced LP-11 hold before next burst (1..255; 0 treated as 1)
// PORTS
//  CLK            in   1  byte clock (OSERDES CLKDIV)
//  RST_N          in   1  asynchronous active-low reset
//  DIN_VALID      in   1  payload byte valid
//  DIN_LAST       in   1  qualifies final byte of burst
//  DIN            in   8  payload byte, bit0 sent first on wire
//  DIN_READY      out  1  byte accepted when DIN_VALID & DIN_READY
//  DOUT           out  8  byte to OSERDES
//  HS_EN          out  1  1 = HS driver enabled (OSERDES tristate off)
//  LP_P, LP_N     out  1  LP driver levels
//  BUSY           out  1  high from burst start until IDLE re-entered
//  ERR_UNDERFLOW  out  1  one-cycle pulse on payload underflow
// BEHAVIOUR
//  Reset (any time, incl. mid-burst, async): state IDLE, DOUT=8'h00, HS_EN=0, LP_P=LP_N=1,
//   DIN_READY=0, BUSY=0, ERR_UNDERFLOW=0, counters cleared.
//  All outputs registered; DIN_READY decoded from registered state (no DIN->READY path).
//  FSM: IDLE -> LPX -> PREP -> HS_ZERO -> SYNC -> DATA -> TRAIL -> EXIT -> IDLE.
//  IDLE: LP=11. DIN_VALID=1 -> next cycle LP=01, BUSY=1 (latency 1).
//  LPX: LP=01 exactly T_LPX cycles. PREP: LP=00 exactly T_HS_PREPARE cycles.
//  HS_ZERO: HS_EN=1, LP=00, DOUT=8'h00 exactly T_HS_ZERO cycles.
//  SYNC: DOUT=8'hB8 one cycle; DIN_READY first asserts this cycle.
//  DATA: DIN_READY=1; byte accepted in cycle n appears on DOUT in cycle n+1, back-to-back.
//   Handshake with DIN_LAST=1 -> DIN_READY drops next cycle; that byte is last payload.
//   DIN_READY=1 & DIN_VALID=0 -> underflow: ERR_UNDERFLOW pulses 1 cycle, burst aborted
//   into TRAIL (last byte = last payload, or 0xB8 if none accepted).
//  TRAIL: HS_EN=1, DOUT={8{~last[7]}} exactly T_HS_TRAIL cycles.
//  EXIT: HS_EN=0, LP=11, DOUT=00 exactly T_HS_EXIT cycles; DIN ignored; then IDLE (BUSY=0).
//  LP_P/LP_N held 0 whenever HS_EN=1. DIN_LAST ignored outside a handshake.
//  Counters: 8-bit down-counters loaded on state entry; no wrap.
//  Minimum idle between bursts: T_HS_EXIT + 1 cycles LP-11 on the wire.
// STRUCTURE
//  Include csi_tx_defines.vh: state encodings, SYNC_BYTE=8'hB8, LP level codes.
//  Sub-module csi_tx_timer: 8-bit loadable down-counter with DONE flag, one instance.
//  OSERDES/IOBUF primitives live in the parent lane PHY, not here.
// TESTING (default parameters)
//  Reset, DIN_VALID=0 100 cycles -> LP=11, HS_EN=0, DOUT=00, BUSY=0 throughout.
//  Burst 01,02,03(LAST) valid held -> LP01x4, LP00x3, 00x10, B8, 01,02,03, FFx5, LP11x6.
//  Last byte 8'h80 -> trail 8'h00 x5; last byte 8'h7F -> trail 8'hFF x5.
//  DIN_VALID drops after 2 of 4 bytes -> ERR_UNDERFLOW pulse 1 cycle, trail follows byte 2.
//  RST_N low during DATA -> same cycle HS_EN=0, LP=11, BUSY=0; new burst starts cleanly.
//  DIN_VALID held across EXIT -> next LP-01 exactly 7 cycles after HS_EN falls.

Source files
------------

// File: rtl/csi_tx_lane_ctrl_pkg.sv
// csi_tx_lane_ctrl_pkg: state encodings, sync byte and LP level codes for the CSI-2 TX lane sequencer.
package csi_tx_lane_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LPX,
        S_PREP,
        S_HS_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // {lp_p, lp_n}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    // A duration of t cycles loads t-1 so the timer's done flag marks the final cycle; 0 acts as 1.
    function automatic logic [7:0] ticks_to_load(input int t);
        return (t <= 1) ? 8'd0 : 8'(t - 1);
    endfunction

endpackage

// File: rtl/csi_tx_timer.sv
// csi_tx_timer: 8-bit loadable down-counter that saturates at zero and flags done there.
module csi_tx_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 8'd0;
        else if (load) cnt <= load_val;
        else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end

    assign done = cnt == 8'd0;

endmodule

// File: rtl/csi_tx_lane_ctrl.sv
// csi_tx_lane_ctrl: single-lane CSI-2 D-PHY transmit sequencer (LP-11/01/00, HS-zero, sync, payload, trail, exit).
module csi_tx_lane_ctrl
    import csi_tx_lane_ctrl_pkg::*;
#(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 10,
    parameter int T_HS_TRAIL   = 5,
    parameter int T_HS_EXIT    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic       din_last,
    input  logic [7:0] din,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       hs_en,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       err_underflow
);

    state_t     state, next;
    logic [7:0] data_q, load_v;
    logic       last_q, err_q, done, load, underflow;

    csi_tx_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .load_val(load_v),
        .done    (done)
    );

    assign din_ready = state == S_SYNC || (state == S_DATA && !last_q);
    assign underflow = din_ready && !din_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            data_q <= 8'h00;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= next;
            err_q <= underflow;
            // Preloading the sync byte makes an underflow in SYNC trail off 0xB8.
            if (state == S_HS_ZERO) begin
                data_q <= SYNC_BYTE;
                last_q <= 1'b0;
            end else if (din_ready && din_valid) begin
                data_q <= din;
                last_q <= din_last;
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:    next = din_valid ? S_LPX : S_IDLE;
            S_LPX:     if (done) next = S_PREP;
            S_PREP:    if (done) next = S_HS_ZERO;
            S_HS_ZERO: if (done) next = S_SYNC;
            S_SYNC:    next = din_valid ? S_DATA : S_TRAIL;
            S_DATA:    next = (last_q || !din_valid) ? S_TRAIL : S_DATA;
            S_TRAIL:   if (done) next = S_EXIT;
            S_EXIT:    if (done) next = S_IDLE;
            default:   next = S_IDLE;
        endcase
        load   = next != state;
        load_v = next == S_LPX     ? ticks_to_load(T_LPX) :
                 next == S_PREP    ? ticks_to_load(T_HS_PREPARE) :
                 next == S_HS_ZERO ? ticks_to_load(T_HS_ZERO) :
                 next == S_TRAIL   ? ticks_to_load(T_HS_TRAIL) :
                 next == S_EXIT    ? ticks_to_load(T_HS_EXIT) : 8'd0;
    end

    always_comb begin
        hs_en         = state inside {S_HS_ZERO, S_SYNC, S_DATA, S_TRAIL};
        {lp_p, lp_n}  = hs_en ? LP_00 : state == S_LPX ? LP_01 : state == S_PREP ? LP_00 : LP_11;
        dout          = state == S_SYNC  ? SYNC_BYTE :
                        state == S_DATA  ? data_q :
                        state == S_TRAIL ? {8{~data_q[7]}} : 8'h00;
        busy          = state != S_IDLE;
        err_underflow = err_q;
    end

endmodule

// File: tb/tb_csi_tx_lane_ctrl.sv
// tb_csi_tx_lane_ctrl: randomized bursts checked every cycle against a burst-timeline model, plus literal pins.
module tb_csi_tx_lane_ctrl;

    localparam int TL = 4, TP = 3, TZ = 10, TT = 5, TX = 6;
    localparam int S  = 1 + TL + TP + TZ;

    typedef struct packed {
        logic [7:0] dout;
        logic       hs;
        logic [1:0] lp;
        logic       rdy;
        logic       busy;
        logic       err;
    } o_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       din_valid = 1'b0, din_last = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_ready, hs_en, lp_p, lp_n, busy, err_underflow;
    logic [7:0] dout;

    o_t         exp_q[$];
    o_t         obs[0:8191];
    logic [7:0] b[0:15];
    int         cyc_i = 0, checks = 0, errors = 0;

    csi_tx_lane_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din          (din),
        .din_ready    (din_ready),
        .dout         (dout),
        .hs_en        (hs_en),
        .lp_p         (lp_p),
        .lp_n         (lp_n),
        .busy         (busy),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic o_t mk(logic [7:0] d, logic hs, logic [1:0] lp, logic r, logic bz, logic e);
        o_t o;
        o.dout = d; o.hs = hs; o.lp = lp; o.rdy = r; o.busy = bz; o.err = e;
        return o;
    endfunction

    always @(negedge clk) begin
        o_t a, e;
        a = {dout, hs_en, lp_p, lp_n, din_ready, busy, err_underflow};
        if (cyc_i < 8192) obs[cyc_i] = a;
        cyc_i++;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle %0d: got dout=%h hs=%b lp=%b rdy=%b busy=%b err=%b, want dout=%h hs=%b lp=%b rdy=%b busy=%b err=%b",
                         cyc_i - 1, a.dout, a.hs, a.lp, a.rdy, a.busy, a.err,
                         e.dout, e.hs, e.lp, e.rdy, e.busy, e.err);
            end
        end
    end

    task automatic pin(input string nm, input logic [7:0] a, input logic [7:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, a, x);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input o_t e);
        @(posedge clk);
        #1;
        din_valid = v;
        din       = d;
        din_last  = l;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int g);
        repeat (g) cyc(1'b0, 8'($urandom), 1'($urandom), mk(8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0));
    endtask

    // n bytes in b[], m accepted before an underflow (m == n: complete burst); stops before cycle cut.
    task automatic run_burst(input int n, input int m, input int cut, output int st);
        logic [7:0] lb, d;
        logic       v, l;
        o_t         e;
        int         k;
        lb = (m == 0) ? 8'hB8 : b[m-1];
        st = 0;
        for (int c = 0; c < S + m + 1 + TT + TX; c++) begin
            if (c == cut) return;
            v = 1'($urandom); d = 8'($urandom); l = 1'($urandom);
            if (c < S) begin
                e = c == 0       ? mk(8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0) :
                    c <= TL      ? mk(8'h00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0) :
                    c <= TL + TP ? mk(8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0) :
                                   mk(8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
                v = 1'b1;
                d = b[0];
            end else if (c <= S + m) begin
                k = c - S;
                e = mk(k == 0 ? 8'hB8 : b[k-1], 1'b1, 2'b00, k != n, 1'b1, 1'b0);
                if (k < m) begin
                    v = 1'b1; d = b[k]; l = k == n - 1;
                end else if (m < n) begin
                    v = 1'b0;
                end
            end else if (c < S + m + 1 + TT) begin
                e = mk({8{~lb[7]}}, 1'b1, 2'b00, 1'b0, 1'b1, (c == S + m + 1) && (m < n));
            end else begin
                e = mk(8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
            end
            cyc(v, d, l, e);
            if (c == 0) st = cyc_i;
        end
    endtask

    initial begin
        int st_a, st_b, st_c, st_d, st_r, st_x;
        repeat (3) @(posedge clk);
        #1;
        pin("reset_dout", dout, 8'h00);
        pin("reset_lp", 8'({lp_p, lp_n}), 8'h03);
        pin("reset_ctl", 8'({hs_en, busy, din_ready, err_underflow}), 8'h00);
        rst_n = 1'b1;
        idle(100);
        b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h03;
        run_burst(3, 3, -1, st_a);
        b[0] = 8'h80;
        run_burst(1, 1, -1, st_b);
        idle(2);
        b[0] = 8'h7F;
        run_burst(1, 1, -1, st_c);
        idle(1);
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        run_burst(4, 2, -1, st_d);
        idle(3);
        // Reset in the middle of DATA, then a clean burst.
        b[0] = 8'hA5; b[1] = 8'h5A; b[2] = 8'hC3; b[3] = 8'h3C;
        run_burst(4, 4, S + 3, st_x);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        pin("rst_mid_hs_en", 8'(hs_en), 8'h00);
        pin("rst_mid_lp", 8'({lp_p, lp_n}), 8'h03);
        pin("rst_mid_busy", 8'(busy), 8'h00);
        pin("rst_mid_dout", dout, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        din_valid = 1'b0;
        b[0] = 8'h42; b[1] = 8'hC0;
        run_burst(2, 2, -1, st_r);
        idle(2);
        for (int i = 0; i < 40; i++) begin
            int n, m;
            n = $urandom_range(1, 8);
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
            for (int j = 0; j < n; j++) b[j] = 8'($urandom);
            run_burst(n, m, -1, st_x);
            idle($urandom_range(0, 3));
        end
        idle(3);
        @(negedge clk);
        #1;
        pin("a_lp01_first", 8'(obs[st_a+1].lp), 8'h01);
        pin("a_lp01_last", 8'(obs[st_a+4].lp), 8'h01);
        pin("a_lp00_first", 8'(obs[st_a+5].lp), 8'h00);
        pin("a_hs_zero_start", {obs[st_a+7].hs, obs[st_a+8].hs, obs[st_a+8].dout[5:0]}, 8'h40);
        pin("a_sync", obs[st_a+18].dout, 8'hB8);
        pin("a_byte1", obs[st_a+19].dout, 8'h01);
        pin("a_byte3", obs[st_a+21].dout, 8'h03);
        pin("a_trail_first", obs[st_a+22].dout, 8'hFF);
        pin("a_trail_last", obs[st_a+26].dout, 8'hFF);
        pin("a_exit_hs_lp", {4'h0, obs[st_a+27].hs, 1'b0, obs[st_a+27].lp}, 8'h03);
        pin("a_exit_busy_end", {obs[st_a+32].busy, obs[st_a+33].busy}, 8'h02);
        pin("chain_lp01_7_after_hs_fall", {obs[st_a+33].lp, obs[st_a+34].lp}, 8'h0D);
        pin("b_trail_80", obs[st_b+20].dout, 8'h00);
        pin("b_trail_80_last", obs[st_b+24].dout, 8'h00);
        pin("c_trail_7f", obs[st_c+20].dout, 8'hFF);
        pin("d_last_before_underflow", obs[st_d+20].dout, 8'h22);
        pin("d_err_pulse", {obs[st_d+20].err, obs[st_d+21].err, obs[st_d+22].err}, 8'h02);
        pin("d_trail", obs[st_d+21].dout, 8'hFF);
        pin("r_sync_after_reset", obs[st_r+18].dout, 8'hB8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
